// File: rtl/memshare_pkg.sv
// memshare_pkg
//   Shared defaults and types for the memShare request-flag skid pipeline.
//   Modules that are re-parameterised carry their own widths; the typedefs
//   here describe the default configuration used across the memShare slice.
package memshare_pkg;

  localparam int DEF_SHARE_GROUP_SIZE = 5;
  localparam int DEF_GROUP_NUM        = 2;
  localparam int DEF_MAX_SKID_DEPTH   = 3;
  localparam int DEF_SEL_W            = $clog2(DEF_MAX_SKID_DEPTH + 1);

  // Depth select value meaning "use the current beat's flags".
  localparam int NOSKID = 0;

  typedef logic [DEF_SHARE_GROUP_SIZE-1:0] rqst_flag_t;
  typedef logic [DEF_SEL_W-1:0]            skid_sel_t;

endpackage

// File: rtl/memshare_skid_hist.sv
// memshare_skid_hist
//   One share group's flag history plus depth mux.  Keeps the flags of the
//   last MAX_SKID_DEPTH accepted beats and returns either the current flags
//   (depth 0) or the flags of the beat accepted 'depth' beats earlier.
//   Depth selects above MAX_SKID_DEPTH are clamped and raise a sticky error.
// Ports
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   flush_i   synchronous clear of history and error flag
//   accept_i  an input beat is taken this cycle (shifts the history)
//   flags_i   this group's request flags of the current beat
//   depth_i   delay select for the current beat
//   sel_o     selected flags (combinational)
//   err_o     sticky: an out-of-range select was accepted
module memshare_skid_hist
  import memshare_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE = DEF_SHARE_GROUP_SIZE,
  parameter int MAX_SKID_DEPTH   = DEF_MAX_SKID_DEPTH,
  parameter int SEL_W            = $clog2(MAX_SKID_DEPTH + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        accept_i,
  input  logic [SHARE_GROUP_SIZE-1:0] flags_i,
  input  logic [SEL_W-1:0]            depth_i,
  output logic [SHARE_GROUP_SIZE-1:0] sel_o,
  output logic                        err_o
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_SKID_DEPTH);

  logic [SHARE_GROUP_SIZE-1:0] hist_q [MAX_SKID_DEPTH];
  logic [SHARE_GROUP_SIZE-1:0] hist_d [MAX_SKID_DEPTH];
  logic                        err_q, err_d;
  logic                        over;
  logic [SEL_W-1:0]            depth_eff;

  // When MAX_SKID_DEPTH fills the select field exactly, no select can be
  // out of range; avoid building a comparison that is constant.
  if (MAX_SKID_DEPTH < (1 << SEL_W) - 1) begin : g_clamp
    assign over = (depth_i > MAX_SEL);
  end else begin : g_noclamp
    assign over = 1'b0;
  end

  assign depth_eff = over ? MAX_SEL : depth_i;

  always_comb begin
    sel_o = flags_i;
    if (depth_eff != SEL_W'(NOSKID)) begin
      for (int k = 0; k < MAX_SKID_DEPTH; k++) begin
        if (depth_eff == SEL_W'(k + 1)) sel_o = hist_q[k];
      end
    end
  end

  always_comb begin
    hist_d = hist_q;
    err_d  = err_q;
    if (flush_i) begin
      for (int k = 0; k < MAX_SKID_DEPTH; k++) hist_d[k] = '0;
      err_d = 1'b0;
    end else if (accept_i) begin
      hist_d[0] = flags_i;
      for (int k = 1; k < MAX_SKID_DEPTH; k++) hist_d[k] = hist_q[k-1];
      if (over) err_d = 1'b1;
    end
  end

  // History stage: shifts once per accepted beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < MAX_SKID_DEPTH; k++) hist_q[k] <= '0;
      err_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/memshare_skid_pipe.sv
// memshare_skid_pipe
//   Skid stage between request-flag generation and the RFMU register file.
//   Each share group picks its current flags or a delayed copy, and the
//   combined vector is registered behind a 2-entry valid/ready skid buffer so
//   downstream backpressure never drops a beat.  rqst_ready_o depends only on
//   registered state (and flush_i), never on rfmu_ready_i.
// Ports
//   sys_clk           clock
//   rst               synchronous active-high reset
//   flush_i           clears history, buffers and cfg_err_o; blocks accept
//   rqst_valid_i      input beat valid
//   rqst_ready_o      input beat accepted when valid & ready
//   share_rqstFlag_i  flags, group g at [g*SHARE_GROUP_SIZE +: SHARE_GROUP_SIZE]
//   skid_depth_i      per-group delay select, group g at [g*SEL_W +: SEL_W]
//   share_rqstFlag_o  selected flags to the RFMU
//   rqst_valid_o      output beat valid
//   rfmu_ready_i      downstream ready
//   cfg_err_o         sticky out-of-range depth select indicator
module memshare_skid_pipe
  import memshare_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE = DEF_SHARE_GROUP_SIZE,
  parameter int GROUP_NUM        = DEF_GROUP_NUM,
  parameter int MAX_SKID_DEPTH   = DEF_MAX_SKID_DEPTH,
  parameter int SEL_W            = $clog2(MAX_SKID_DEPTH + 1)
) (
  input  logic                                  sys_clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic                                  rqst_valid_i,
  output logic                                  rqst_ready_o,
  input  logic [GROUP_NUM*SHARE_GROUP_SIZE-1:0] share_rqstFlag_i,
  input  logic [GROUP_NUM*SEL_W-1:0]            skid_depth_i,
  output logic [GROUP_NUM*SHARE_GROUP_SIZE-1:0] share_rqstFlag_o,
  output logic                                  rqst_valid_o,
  input  logic                                  rfmu_ready_i,
  output logic                                  cfg_err_o
);

  localparam int FLAG_W = GROUP_NUM * SHARE_GROUP_SIZE;

  logic              accept, pop;
  logic [FLAG_W-1:0] sel_flags;
  logic [GROUP_NUM-1:0] grp_err;

  logic [FLAG_W-1:0] main_data_q, main_data_d;
  logic              main_vld_q,  main_vld_d;
  logic [FLAG_W-1:0] skid_data_q, skid_data_d;
  logic              skid_vld_q,  skid_vld_d;

  assign rqst_ready_o = ~skid_vld_q & ~flush_i;
  assign accept       = rqst_valid_i & rqst_ready_o;
  assign pop          = main_vld_q & rfmu_ready_i;

  // Select stage: per-group history and depth mux
  for (genvar g = 0; g < GROUP_NUM; g++) begin : g_grp
    memshare_skid_hist #(
      .SHARE_GROUP_SIZE (SHARE_GROUP_SIZE),
      .MAX_SKID_DEPTH   (MAX_SKID_DEPTH),
      .SEL_W            (SEL_W)
    ) u_hist (
      .clk_i    (sys_clk),
      .rst_i    (rst),
      .flush_i  (flush_i),
      .accept_i (accept),
      .flags_i  (share_rqstFlag_i[g*SHARE_GROUP_SIZE +: SHARE_GROUP_SIZE]),
      .depth_i  (skid_depth_i[g*SEL_W +: SEL_W]),
      .sel_o    (sel_flags[g*SHARE_GROUP_SIZE +: SHARE_GROUP_SIZE]),
      .err_o    (grp_err[g])
    );
  end

  // Buffer control: the skid entry is only ever filled while main is held,
  // and since ready drops whenever skid is occupied, a skid->main transfer
  // can never coincide with a new accept.
  always_comb begin
    main_data_d = main_data_q;
    main_vld_d  = main_vld_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    if (flush_i) begin
      main_data_d = '0;
      main_vld_d  = 1'b0;
      skid_data_d = '0;
      skid_vld_d  = 1'b0;
    end else if (!main_vld_q || pop) begin
      if (skid_vld_q) begin
        main_data_d = skid_data_q;
        main_vld_d  = 1'b1;
        skid_vld_d  = 1'b0;
      end else if (accept) begin
        main_data_d = sel_flags;
        main_vld_d  = 1'b1;
      end else begin
        main_vld_d  = 1'b0;
      end
    end else if (accept) begin
      skid_data_d = sel_flags;
      skid_vld_d  = 1'b1;
    end
  end

  // Output stage: main and skid registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      main_data_q <= '0;
      main_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_vld_q  <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
    end
  end

  assign share_rqstFlag_o = main_data_q;
  assign rqst_valid_o     = main_vld_q;
  assign cfg_err_o        = |grp_err;

endmodule

// File: tb/tb_memshare_skid_pipe.sv
// Directed bench for memshare_skid_pipe.  MAX_SKID_DEPTH is set to 4 so the
// 3-bit select field can carry out-of-range values (e.g. 7).
module tb_memshare_skid_pipe;

  localparam int SGS  = 5;
  localparam int GN   = 2;
  localparam int MAXD = 4;
  localparam int SW   = $clog2(MAXD + 1);

  logic          sys_clk = 1'b0;
  logic          rst, flush_i, rqst_valid_i, rfmu_ready_i;
  logic          rqst_ready_o, rqst_valid_o, cfg_err_o;
  logic [GN*SGS-1:0] flags_i, flags_o;
  logic [GN*SW-1:0]  depth_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  memshare_skid_pipe #(
    .SHARE_GROUP_SIZE (SGS),
    .GROUP_NUM        (GN),
    .MAX_SKID_DEPTH   (MAXD)
  ) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .rqst_valid_i     (rqst_valid_i),
    .rqst_ready_o     (rqst_ready_o),
    .share_rqstFlag_i (flags_i),
    .skid_depth_i     (depth_i),
    .share_rqstFlag_o (flags_o),
    .rqst_valid_o     (rqst_valid_o),
    .rfmu_ready_i     (rfmu_ready_i),
    .cfg_err_o        (cfg_err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [9:0] fl(input logic [4:0] g1, input logic [4:0] g0);
    return {g1, g0};
  endfunction

  task automatic drive(input logic v, input logic [4:0] g1, input logic [4:0] g0,
                       input logic [2:0] d1, input logic [2:0] d0);
    rqst_valid_i = v;
    flags_i      = {g1, g0};
    depth_i      = {d1, d0};
  endtask

  task automatic do_flush(input string tag);
    flush_i = 1'b1;
    #1;
    check_eq(tag, 32'(rqst_ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
  endtask

  function automatic logic [9:0] beat(input int s);
    logic [4:0] b;
    b = s[4:0];
    return {~b, b};
  endfunction

  initial begin
    int sent, recv;
    logic acc, pp;

    rst = 1'b1; flush_i = 1'b0; rqst_valid_i = 1'b0; rfmu_ready_i = 1'b1;
    flags_i = '0; depth_i = '0;
    tick(); tick();
    check_eq("rst_vld",   32'(rqst_valid_o), 32'd0);
    check_eq("rst_flags", 32'(flags_o),      32'd0);
    check_eq("rst_err",   32'(cfg_err_o),    32'd0);
    check_eq("rst_rdy",   32'(rqst_ready_o), 32'd1);
    rst = 1'b0;

    // Back-to-back beats, no delay
    drive(1, 5'h01, 5'h01, 0, 0); tick();
    check_eq("t1_a_vld", 32'(rqst_valid_o), 32'd1);
    check_eq("t1_a",     32'(flags_o), 32'(fl(5'h01, 5'h01)));
    drive(1, 5'h02, 5'h02, 0, 0); tick();
    check_eq("t1_b",     32'(flags_o), 32'(fl(5'h02, 5'h02)));
    drive(0, 0, 0, 0, 0); tick();
    check_eq("t1_drain", 32'(rqst_valid_o), 32'd0);
    check_eq("t1_err",   32'(cfg_err_o), 32'd0);
    do_flush("t1_flush_rdy");

    // Group0 delayed by 2 beats, group1 undelayed
    drive(1, 5'h03, 5'h03, 0, 2); tick();
    check_eq("t2_a", 32'(flags_o), 32'(fl(5'h03, 5'h00)));
    drive(1, 5'h05, 5'h05, 0, 2); tick();
    check_eq("t2_b", 32'(flags_o), 32'(fl(5'h05, 5'h00)));
    drive(1, 5'h11, 5'h11, 0, 2); tick();
    check_eq("t2_c", 32'(flags_o), 32'(fl(5'h11, 5'h03)));
    drive(0, 0, 0, 0, 0); tick();

    // Backpressure for 3 cycles
    rfmu_ready_i = 1'b0;
    drive(1, 5'h06, 5'h06, 0, 0); tick();
    check_eq("t3_d1",      32'(flags_o), 32'(fl(5'h06, 5'h06)));
    check_eq("t3_rdy1",    32'(rqst_ready_o), 32'd1);
    drive(1, 5'h07, 5'h07, 0, 0); tick();
    check_eq("t3_hold1",   32'(flags_o), 32'(fl(5'h06, 5'h06)));
    check_eq("t3_rdy2",    32'(rqst_ready_o), 32'd0);
    drive(1, 5'h08, 5'h08, 0, 0); tick();
    check_eq("t3_hold2",   32'(flags_o), 32'(fl(5'h06, 5'h06)));
    check_eq("t3_rdy3",    32'(rqst_ready_o), 32'd0);
    rfmu_ready_i = 1'b1; tick();
    check_eq("t3_d2",      32'(flags_o), 32'(fl(5'h07, 5'h07)));
    check_eq("t3_rdy4",    32'(rqst_ready_o), 32'd1);
    tick();
    check_eq("t3_d3",      32'(flags_o), 32'(fl(5'h08, 5'h08)));
    check_eq("t3_d3_vld",  32'(rqst_valid_o), 32'd1);
    drive(0, 0, 0, 0, 0); tick();
    check_eq("t3_empty",   32'(rqst_valid_o), 32'd0);

    // Out-of-range select clamps to MAXD and sets sticky error
    do_flush("t4_pre_flush_rdy");
    drive(1, 5'h0A, 5'h0A, 0, 0); tick();
    drive(1, 5'h0B, 5'h0B, 0, 0); tick();
    drive(1, 5'h0C, 5'h0C, 0, 0); tick();
    drive(1, 5'h0D, 5'h0D, 0, 0); tick();
    check_eq("t4_d0",      32'(flags_o), 32'(fl(5'h0D, 5'h0D)));
    check_eq("t4_err0",    32'(cfg_err_o), 32'd0);
    drive(1, 5'h0E, 5'h0E, 0, 7); tick();
    check_eq("t4_clamp",   32'(flags_o), 32'(fl(5'h0E, 5'h0A)));
    check_eq("t4_err1",    32'(cfg_err_o), 32'd1);
    drive(1, 5'h0F, 5'h0F, 0, 0); tick();
    check_eq("t4_after",   32'(flags_o), 32'(fl(5'h0F, 5'h0F)));
    check_eq("t4_sticky",  32'(cfg_err_o), 32'd1);
    drive(0, 0, 0, 0, 0); tick();
    check_eq("t4_sticky2", 32'(cfg_err_o), 32'd1);
    do_flush("t4_flush_rdy");
    check_eq("t4_err_clr", 32'(cfg_err_o), 32'd0);
    check_eq("t4_vld_clr", 32'(rqst_valid_o), 32'd0);

    // Flush with both entries full and a valid input beat
    rfmu_ready_i = 1'b0;
    drive(1, 5'h11, 5'h11, 0, 0); tick();
    drive(1, 5'h12, 5'h12, 0, 0); tick();
    check_eq("t5_full_rdy", 32'(rqst_ready_o), 32'd0);
    drive(1, 5'h13, 5'h13, 0, 0);
    do_flush("t5_flush_rdy");
    drive(0, 0, 0, 0, 0); #1;
    check_eq("t5_vld",   32'(rqst_valid_o), 32'd0);
    check_eq("t5_flags", 32'(flags_o), 32'd0);
    check_eq("t5_rdy",   32'(rqst_ready_o), 32'd1);
    rfmu_ready_i = 1'b1;
    drive(1, 5'h14, 5'h14, 1, 1); tick();
    check_eq("t5_hist_clr", 32'(flags_o), 32'(fl(5'h00, 5'h00)));
    check_eq("t5_hist_vld", 32'(rqst_valid_o), 32'd1);
    drive(1, 5'h15, 5'h15, 1, 1); tick();
    check_eq("t5_no_acc",   32'(flags_o), 32'(fl(5'h14, 5'h14)));
    drive(0, 0, 0, 0, 0); tick();

    // Reset mid-stream
    rfmu_ready_i = 1'b0;
    drive(1, 5'h16, 5'h16, 0, 0); tick();
    drive(1, 5'h17, 5'h17, 0, 0); tick();
    rst = 1'b1;
    drive(1, 5'h18, 5'h18, 0, 0); tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0); #1;
    check_eq("t6_vld",   32'(rqst_valid_o), 32'd0);
    check_eq("t6_flags", 32'(flags_o), 32'd0);
    check_eq("t6_rdy",   32'(rqst_ready_o), 32'd1);
    rfmu_ready_i = 1'b1;
    drive(1, 5'h19, 5'h19, 1, 1); tick();
    check_eq("t6_hist_clr", 32'(flags_o), 32'd0);
    drive(0, 0, 0, 0, 0); tick();

    // Random valid/ready: beats must leave in order, none lost or repeated
    sent = 0;
    recv = 0;
    depth_i = '0;
    for (int c = 0; c < 2000; c++) begin
      rqst_valid_i = ($urandom_range(0, 3) != 0);
      rfmu_ready_i = ($urandom_range(0, 2) != 0);
      flags_i      = beat(sent);
      #1;
      acc = rqst_valid_i & rqst_ready_o;
      pp  = rqst_valid_o & rfmu_ready_i;
      if (pp) begin
        check_eq("t7_order", 32'(flags_o), 32'(beat(recv)));
        recv++;
      end
      tick();
      if (acc) sent++;
    end
    rqst_valid_i = 1'b0;
    rfmu_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (rqst_valid_o) begin
        check_eq("t7_drain", 32'(flags_o), 32'(beat(recv)));
        recv++;
      end
      tick();
    end
    check_eq("t7_count", 32'(recv), 32'(sent));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
